// File: rtl/fetch_group_unit.sv
// rtl/fetch_group_unit.sv - fetch stage: one 4-word imem request at a time, group hand-off, next-PC select
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   has_mispredict      backend redirect; highest priority next-PC source
//   mispredict_pc       redirect target, taken when has_mispredict=1
//   jump_for_pcsel      jump handler picks jump_addr_pc as the next PC
//   jump_addr_pc        jump target from the jump handler
//   decode_stall        downstream cannot take the presented group
//   imem_req            one-cycle request strobe (memory always accepts)
//   imem_addr           request address (the fetch_pc register)
//   imem_rdata          response: [15:0]=addr, [31:16]=addr+1, [47:32]=addr+2, [63:48]=addr+3
//   imem_rvalid         response strobe, one per request
//   pc                  address of instruction0 of the presented group
//   instruction0..3     presented group words, 16'h0000 when group_valid=0
//   group_valid         a group is presented this cycle
module fetch_group_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        has_mispredict,
  input  logic [15:0] mispredict_pc,
  input  logic        jump_for_pcsel,
  input  logic [15:0] jump_addr_pc,
  input  logic        decode_stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [63:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [15:0] pc,
  output logic [15:0] instruction0,
  output logic [15:0] instruction1,
  output logic [15:0] instruction2,
  output logic [15:0] instruction3,
  output logic        group_valid
);

  // DROP means a request is outstanding whose response must be thrown away.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DROP  = 3'd3,
    S_VALID = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] fetch_pc;
  logic [15:0] fetch_pc_nxt;
  logic [15:0] pc_q;
  logic [15:0] pc_nxt;
  logic [63:0] grp;
  logic [63:0] grp_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      pc_q     <= 16'h0000;
      grp      <= 64'h0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pc_q     <= pc_nxt;
      grp      <= grp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pc_nxt       = pc_q;
    grp_nxt      = grp;
    imem_req     = 1'b0;
    group_valid  = 1'b0;

    case (state)
      S_IDLE: begin
        if (has_mispredict) fetch_pc_nxt = mispredict_pc;
        state_nxt = S_ISSUE;
      end

      S_ISSUE: begin
        imem_req = 1'b1;
        // The request leaves this cycle regardless, so a redirect here
        // makes its response stale.
        if (has_mispredict) begin
          fetch_pc_nxt = mispredict_pc;
          state_nxt    = S_DROP;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (has_mispredict) begin
          fetch_pc_nxt = mispredict_pc;
          // Response landing in the same cycle is already consumed (and
          // discarded), so no DROP cycle is needed.
          state_nxt    = imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem_rvalid) begin
          grp_nxt   = imem_rdata;
          pc_nxt    = fetch_pc;
          state_nxt = S_VALID;
        end
      end

      S_DROP: begin
        if (has_mispredict) fetch_pc_nxt = mispredict_pc;
        if (imem_rvalid) state_nxt = S_ISSUE;
      end

      S_VALID: begin
        group_valid = 1'b1;
        if (has_mispredict) begin
          fetch_pc_nxt = mispredict_pc;
          state_nxt    = S_ISSUE;
        end else if (!decode_stall) begin
          // Wraps modulo 2^16.
          fetch_pc_nxt = jump_for_pcsel ? jump_addr_pc : (pc_q + 16'd4);
          state_nxt    = S_ISSUE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem_addr    = fetch_pc;
  assign pc           = pc_q;
  assign instruction0 = group_valid ? grp[15:0]  : 16'h0000;
  assign instruction1 = group_valid ? grp[31:16] : 16'h0000;
  assign instruction2 = group_valid ? grp[47:32] : 16'h0000;
  assign instruction3 = group_valid ? grp[63:48] : 16'h0000;

endmodule

// File: tb/tb_fetch_group_unit.sv
// tb/tb_fetch_group_unit.sv - bench for fetch_group_unit: memory model, reference model, directed and random checks
module tb_fetch_group_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        has_mispredict;
  logic [15:0] mispredict_pc;
  logic        jump_for_pcsel;
  logic [15:0] jump_addr_pc;
  logic        decode_stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        imem_rvalid;
  logic [15:0] pc;
  logic [15:0] instruction0;
  logic [15:0] instruction1;
  logic [15:0] instruction2;
  logic [15:0] instruction3;
  logic        group_valid;

  always #5 clk = ~clk;

  fetch_group_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .has_mispredict (has_mispredict),
    .mispredict_pc  (mispredict_pc),
    .jump_for_pcsel (jump_for_pcsel),
    .jump_addr_pc   (jump_addr_pc),
    .decode_stall   (decode_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .pc             (pc),
    .instruction0   (instruction0),
    .instruction1   (instruction1),
    .instruction2   (instruction2),
    .instruction3   (instruction3),
    .group_valid    (group_valid)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // memory model
  logic        mem_pend = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  int          mem_cnt = 0;
  int          lat_fixed = 1;

  // reference model: fetch activity as flags, not as an encoded state
  logic        m_warm, m_issue, m_out, m_stale, m_hold;
  logic [15:0] m_fetch, m_pc, m_req_addr;

  // logs of observed requests and presented groups
  logic [15:0] req_addr_q[$];
  int          req_cyc_q[$];
  int          valid_cyc_q[$];
  logic [15:0] valid_pc_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    return {mem_word(a + 16'd3), mem_word(a + 16'd2), mem_word(a + 16'd1), mem_word(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_warm = 1'b1; m_issue = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
    m_fetch = 16'h0000; m_pc = 16'h0000; m_req_addr = 16'h0000;
  endtask

  task automatic model_step();
    if (m_warm) begin
      m_warm  = 1'b0;
      m_issue = 1'b1;
      if (has_mispredict) m_fetch = mispredict_pc;
    end else if (m_issue) begin
      m_issue    = 1'b0;
      m_out      = 1'b1;
      m_req_addr = m_fetch;
      m_stale    = has_mispredict;
      if (has_mispredict) m_fetch = mispredict_pc;
    end else if (m_out) begin
      if (has_mispredict) begin
        m_fetch = mispredict_pc;
        m_stale = 1'b1;
      end
      if (imem_rvalid) begin
        m_out = 1'b0;
        if (m_stale) m_issue = 1'b1;
        else begin
          m_hold = 1'b1;
          m_pc   = m_req_addr;
        end
      end
    end else if (m_hold) begin
      if (has_mispredict) begin
        m_hold = 1'b0; m_issue = 1'b1; m_fetch = mispredict_pc;
      end else if (!decode_stall) begin
        m_hold = 1'b0; m_issue = 1'b1;
        m_fetch = jump_for_pcsel ? jump_addr_pc : m_pc + 16'd4;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance model, then drive memory after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    chk("imem_req", imem_req, m_issue);
    chk("imem_addr", imem_addr, m_fetch);
    chk("group_valid", group_valid, m_hold);
    chk("pc", pc, m_pc);
    chk("instruction0", instruction0, m_hold ? mem_word(m_pc) : 16'h0000);
    chk("instruction1", instruction1, m_hold ? mem_word(m_pc + 16'd1) : 16'h0000);
    chk("instruction2", instruction2, m_hold ? mem_word(m_pc + 16'd2) : 16'h0000);
    chk("instruction3", instruction3, m_hold ? mem_word(m_pc + 16'd3) : 16'h0000);
    if (rst_n && imem_req) begin
      req_addr_q.push_back(imem_addr);
      req_cyc_q.push_back(cyc);
      chk("one_outstanding", mem_pend, 1'b0);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
    end
    if (rst_n && group_valid) begin
      valid_cyc_q.push_back(cyc);
      valid_pc_q.push_back(pc);
    end
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = {$urandom, $urandom};
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_line(mem_addr);
        mem_pend    = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk({name, "_req_seen"}, imem_req, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!group_valid && n < 20) begin tick(); n++; end
    chk({name, "_valid_seen"}, group_valid, 1'b1);
  endtask

  initial begin
    int d_cyc, nv, nr;
    rst_n = 1'b0; has_mispredict = 1'b0; mispredict_pc = 16'h0;
    jump_for_pcsel = 1'b0; jump_addr_pc = 16'h0; decode_stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 64'h0;
    model_reset();
    tick(); tick();
    chk("reset_imem_req", imem_req, 1'b0);
    chk("reset_imem_addr", imem_addr, 16'h0000);
    chk("reset_pc", pc, 16'h0000);
    chk("reset_group_valid", group_valid, 1'b0);
    chk("reset_instruction0", instruction0, 16'h0000);

    // sequential fetch, 1-cycle memory
    rst_n = 1'b1;
    d_cyc = cyc;
    for (int i = 0; i < 12; i++) tick();
    chk("seq_req_count_ge3", req_addr_q.size() >= 3, 1'b1);
    chk("seq_valid_count_ge3", valid_cyc_q.size() >= 3, 1'b1);
    if (req_addr_q.size() >= 3 && valid_cyc_q.size() >= 3) begin
      chk("first_req_cycle", req_cyc_q[0] - d_cyc, 2);
      chk("seq_addr0", req_addr_q[0], 16'h0000);
      chk("seq_addr1", req_addr_q[1], 16'h0004);
      chk("seq_addr2", req_addr_q[2], 16'h0008);
      chk("seq_valid_gap1", valid_cyc_q[1] - valid_cyc_q[0], 3);
      chk("seq_valid_gap2", valid_cyc_q[2] - valid_cyc_q[1], 3);
      chk("seq_valid_pc1", valid_pc_q[1], 16'h0004);
    end

    // jump selection
    wait_valid("jump");
    jump_for_pcsel = 1'b1; jump_addr_pc = 16'h0123;
    tick();
    jump_for_pcsel = 1'b0;
    chk("jump_req", imem_req, 1'b1);
    chk("jump_addr", imem_addr, 16'h0123);
    wait_valid("jump_group");
    chk("jump_group_pc", pc, 16'h0123);
    chk("jump_group_ins0", instruction0, 16'h793D);

    // mispredict in WAIT, late response dropped
    lat_fixed = 3;
    wait_req("mp_wait");
    tick();
    has_mispredict = 1'b1; mispredict_pc = 16'h0400;
    tick();
    has_mispredict = 1'b0;
    nv = valid_cyc_q.size();
    wait_req("mp_wait_reissue");
    chk("mp_wait_addr", imem_addr, 16'h0400);
    chk("mp_wait_no_group", valid_cyc_q.size(), nv);

    // mispredict together with rvalid: direct reissue
    lat_fixed = 2;
    tick(); tick();
    has_mispredict = 1'b1; mispredict_pc = 16'h0400;
    tick();
    has_mispredict = 1'b0;
    chk("mp_same_req", imem_req, 1'b1);
    chk("mp_same_addr", imem_addr, 16'h0400);

    // decode stall for 4 cycles, then a mispredict during the stall
    lat_fixed = 1;
    wait_valid("stall");
    decode_stall = 1'b1;
    nr = req_addr_q.size();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", group_valid, 1'b1);
      chk("stall_pc", pc, 16'h0400);
      chk("stall_ins0", instruction0, 16'h5A38);
      chk("stall_ins3", instruction3, 16'h5938);
    end
    chk("stall_no_req", req_addr_q.size(), nr);
    has_mispredict = 1'b1; mispredict_pc = 16'h0777;
    tick();
    has_mispredict = 1'b0; decode_stall = 1'b0;
    chk("stall_mp_valid", group_valid, 1'b0);
    chk("stall_mp_req", imem_req, 1'b1);
    chk("stall_mp_addr", imem_addr, 16'h0777);

    // pc+4 wraps
    wait_valid("wrap_pre");
    has_mispredict = 1'b1; mispredict_pc = 16'hFFFE;
    tick();
    has_mispredict = 1'b0;
    wait_valid("wrap");
    chk("wrap_pc", pc, 16'hFFFE);
    chk("wrap_ins2", instruction2, 16'h5A3C);
    chk("wrap_ins3", instruction3, 16'h5B3C);
    tick();
    chk("wrap_req", imem_req, 1'b1);
    chk("wrap_addr", imem_addr, 16'h0002);

    // two mispredicts while in DROP: newest wins
    lat_fixed = 3;
    tick();
    has_mispredict = 1'b1; mispredict_pc = 16'h0100;
    tick();
    mispredict_pc = 16'h0200;
    tick();
    has_mispredict = 1'b0;
    nv = valid_cyc_q.size();
    wait_req("drop2");
    chk("drop2_addr", imem_addr, 16'h0200);
    chk("drop2_no_group", valid_cyc_q.size(), nv);

    // randomized traffic with occasional mid-run resets
    lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        rst_n = 1'b0; has_mispredict = 1'b0; decode_stall = 1'b0; jump_for_pcsel = 1'b0;
        tick(); tick(); tick();
        mem_pend = 1'b0;
        rst_n = 1'b1;
      end
      has_mispredict = ($urandom_range(0, 9) == 0);
      mispredict_pc  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                   : 16'($urandom);
      jump_for_pcsel = ($urandom_range(0, 2) == 0);
      jump_addr_pc   = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      decode_stall   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_group_unit.md
# fetch_group_unit

Front-end fetch stage that sits directly upstream of the jump handler. It owns the fetch PC, issues one 4-word request at a time to instruction memory, and presents the returned group (pc, instruction0..3) to the jump handler. It then selects the next PC from three sources, in priority order: mispredict redirect, the jump handler's `jump_for_pcsel`/`jump_addr_pc`, or sequential pc+4. Stale memory responses after a redirect are discarded.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- has_mispredict  in  1  redirect request from the backend; highest priority.
- mispredict_pc  in  16  redirect target, sampled when has_mispredict=1.
- jump_for_pcsel  in  1  jump handler selects jump_addr_pc as the next PC (combinational from the current group).
- jump_addr_pc  in  16  jump target from the jump handler.
- decode_stall  in  1  downstream cannot accept the current group.
- imem_req  out  1  one-cycle request strobe; memory always accepts it.
- imem_addr  out  16  request address (= fetch_pc register).
- imem_rdata  in  64  response: [15:0]=word at addr, [31:16]=addr+1, [47:32]=addr+2, [63:48]=addr+3.
- imem_rvalid  in  1  response strobe, ≥1 cycle after imem_req; one response per request.
- pc  out  16  address of instruction0 of the presented group.
- instruction0..instruction3  out  16 each  presented group; 16'h0000 (NOP) when group_valid=0.
- group_valid  out  1  group is presented this cycle.

## Operation
- Registers: state, fetch_pc[15:0], pc[15:0], grp[63:0].
- States: IDLE, ISSUE, WAIT, DROP, VALID. Only one request is outstanding at any time.
- IDLE: entered on reset. Next cycle → ISSUE. A mispredict in IDLE loads fetch_pc.
- ISSUE: imem_req=1, imem_addr=fetch_pc.
  - Normally → WAIT.
  - If has_mispredict: fetch_pc<=mispredict_pc → DROP, because the request already sent is stale.
- WAIT:
  - If has_mispredict: fetch_pc<=mispredict_pc. If imem_rvalid is also high this cycle, discard the data → ISSUE; otherwise → DROP.
  - Else if imem_rvalid: grp<=imem_rdata, pc<=fetch_pc → VALID.
- DROP: imem_rvalid → ISSUE, data discarded. If has_mispredict, fetch_pc<=mispredict_pc; the newest redirect wins.
- VALID: group_valid=1, outputs = grp slices.
  - has_mispredict: fetch_pc<=mispredict_pc → ISSUE, group dropped. This overrides decode_stall.
  - else decode_stall: hold all registers, stay VALID.
  - else: fetch_pc <= jump_for_pcsel ? jump_addr_pc : pc+16'd4 → ISSUE.
- Arithmetic: pc+4 is 16-bit and wraps modulo 2^16 (16'hFFFE → 16'h0002). Groups need not be aligned.
- imem_rvalid outside WAIT/DROP is a protocol error and is ignored.
- The stall-on-register-jump loop is driven by the jump handler holding jump_for_pcsel=1 with the same address; this block simply refetches it. It needs no stall_for_jump input.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=16'h0000, group_valid=0, instruction0..3=16'h0000, state=IDLE.
- First request: imem_req high in the 2nd cycle after rst_n deasserts.
- With 1-cycle memory: req at cycle N, rvalid at N+1, group_valid at N+2, next req at N+3. Peak rate is 1 group per 3 cycles.
- The next-PC decision uses jump_for_pcsel/jump_addr_pc from the cycle the group is consumed (VALID & !decode_stall & !has_mispredict).
- Asserting rst_n low mid-request returns to IDLE immediately. The outstanding response, if any, arrives in IDLE and is ignored.

## Test plan
- Reset, 1-cycle memory, no jumps:
  - required: imem_addr sequence 0000, 0004, 0008.
  - required: group_valid every 3rd cycle, pc matches imem_addr, instruction0 = imem_rdata[15:0].
- VALID with jump_for_pcsel=1, jump_addr_pc=16'h0123 → next imem_addr=0123, and the following group has pc=0123.
- has_mispredict=1, mispredict_pc=16'h0400 while in WAIT (3-cycle memory):
  - required: the late response is dropped and group_valid stays 0.
  - required: the next request is 0400.
  - required: mispredict and rvalid in the same cycle → immediate ISSUE of 0400, with no DROP cycle.
- decode_stall held 4 cycles in VALID:
  - required: pc and instructions stable, no imem_req.
  - required: a mispredict during the stall → group_valid=0 next cycle, then a request to the redirect target.
- pc=16'hFFFE, sequential → next imem_addr=16'h0002.
- Two mispredicts (0100, then 0200) while in DROP → the single next request is 0200.
